afifo_rd_stream: RTL

AFIFO_RD_STREAM -- requirements
Module: afifo_rd_stream

---
 rtl/afifo_pkg.sv | 12 +
 rtl/afifo_rd_stream.sv | 96 +++++++++
 2 files changed

// File: rtl/afifo_pkg.sv
// Shared definitions for the async-FIFO read-side helpers.
package afifo_pkg;

  localparam int XFER_CNT_W = 16;

  typedef enum logic [1:0] {
    OCC0 = 2'd0,
    OCC1 = 2'd1,
    OCC2 = 2'd2
  } occ_state_t;

endpackage

// File: rtl/afifo_rd_stream.sv
// Turns the read side of an async FIFO into a valid/ready stream via a
// 2-entry skid buffer, so the pop decision never waits on a registered m_ready.
module afifo_rd_stream
  import afifo_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic                  rclk,
  input  logic                  rrstn,
  input  logic                  fifo_rempty,
  input  logic [DW-1:0]         fifo_rdata,
  output logic                  fifo_rden,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DW-1:0]         m_data,
  output logic [1:0]            occ,
  output logic [XFER_CNT_W-1:0] xfer_cnt
);

  occ_state_t    state;
  occ_state_t    state_nxt;
  logic [DW-1:0] head;
  logic [DW-1:0] tail;
  logic          out_pop;

  assign out_pop = (state != OCC0) & m_ready;

  always_ff @(posedge rclk) begin
    if (!rrstn) begin
      state <= OCC0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = OCC0;
    end else begin
      case (state)
        OCC0: if (fifo_rden) state_nxt = OCC1;
        OCC1: begin
          if (fifo_rden && !out_pop) state_nxt = OCC2;
          else if (!fifo_rden && out_pop) state_nxt = OCC0;
        end
        OCC2: if (out_pop && !fifo_rden) state_nxt = OCC1;
        default: state_nxt = OCC0;
      endcase
    end
  end

  // Popping while full is allowed when the head leaves on the same edge.
  always_comb begin
    m_valid   = (state != OCC0);
    occ       = state;
    fifo_rden = rrstn & ~fifo_rempty & ~flush & ((state != OCC2) | out_pop);
  end

  always_ff @(posedge rclk) begin
    if (!rrstn) begin
      head <= '0;
      tail <= '0;
    end else if (!flush) begin
      case (state)
        OCC0: if (fifo_rden) head <= fifo_rdata;
        OCC1: begin
          if (fifo_rden) begin
            if (out_pop) head <= fifo_rdata;
            else         tail <= fifo_rdata;
          end
        end
        OCC2: begin
          if (out_pop) begin
            head <= tail;
            if (fifo_rden) tail <= fifo_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Flush cancels any transfer on its edge; the counter survives flush.
  always_ff @(posedge rclk) begin
    if (!rrstn) begin
      xfer_cnt <= '0;
    end else if (out_pop && !flush && (xfer_cnt != {XFER_CNT_W{1'b1}})) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

  assign m_data = head;

endmodule
